// File: rtl/regfile_scan_reader.sv
// regfile_scan_reader
// Walks REG_FILE read addresses FIRST_ADDR..LAST_ADDR after a start pulse.
// Each word is captured and presented with its address on a valid/ready stream.
// A one-cycle done pulse follows acceptance of the last word.
// Optional feature macro: REGFILE_SCAN_SUM_EN adds a running `sum` output.
// It accumulates the accepted words modulo 2^DATA_W.
module regfile_scan_reader #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 32,
    parameter int FIRST_ADDR = 0,
    parameter int LAST_ADDR  = 63
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done
`ifdef REGFILE_SCAN_SUM_EN
    ,
    output logic [DATA_W-1:0] sum
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        PRESENT = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_ADDR);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_ADDR);

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] addr;
    logic              hs;

    assign hs = out_valid & out_ready;

    // State register; reset is synchronous, so it only acts at a clock edge.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register
        // samples pre-edge values, independent of statement order.
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state decode plus the Moore outputs busy, done and rd_addr.
    always_comb begin
        // NOTE: every output gets a default before the case, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_nx = state;
        busy     = 1'b1;
        done     = 1'b0;
        rd_addr  = FIRST_A;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nx = FETCH;
            end
            FETCH: begin
                rd_addr  = addr;
                state_nx = PRESENT;
            end
            PRESENT: begin
                // rd_addr holds the word's address while the sink stalls.
                rd_addr = addr;
                if (hs) state_nx = (addr == LAST_A) ? DONE : FETCH;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Scan address and output word: capture in FETCH, hold through PRESENT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr      <= FIRST_A;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) addr <= FIRST_A;
                end
                FETCH: begin
                    // No forwarding: whatever rd_data shows now is the word.
                    out_data  <= rd_data;
                    out_addr  <= addr;
                    out_valid <= 1'b1;
                end
                PRESENT: begin
                    if (hs) begin
                        out_valid <= 1'b0;
                        // The final address is never incremented, so addr
                        // cannot wrap past LAST_ADDR.
                        if (addr != LAST_A) addr <= addr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef REGFILE_SCAN_SUM_EN
    // Running sum of accepted words; cleared on an accepted start.
    always_ff @(posedge clk) begin
        if (!rst_n)                          sum <= '0;
        else if ((state == IDLE) && start)   sum <= '0;
        else if ((state == PRESENT) && hs)   sum <= sum + out_data;
    end
`endif

endmodule
